wr_ptr_full_gen: RTL and testbench
==================================

WR_PTR_FULL_GEN -- requirements
Module: wr_ptr_full_gen

Interface
REQ-001 The block SHALL have parameter ADDR_SIZE, default 4: address width; FIFO depth = 2**ADDR_SIZE; legal range 2..16.
REQ-002 The block SHALL have parameter AFULL_TH, default 2**ADDR_SIZE-2: almost-full threshold in entries; legal range 1..2**ADDR_SIZE.
REQ-003 The block SHALL have port wclk, input, 1 bit: write-domain clock; single clock, all logic on its rising edge.
REQ-004 The block SHALL have port wrst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port winc, input, 1 bit: write request.
REQ-006 The block SHALL have port r_sync, input, ADDR_SIZE+1 bits: Gray-coded read pointer, already synchronised into wclk.
REQ-007 The block SHALL have port wovf_clr, input, 1 bit: clears the sticky overflow flag.
REQ-008 The block SHALL have port waddr, output, ADDR_SIZE bits: RAM write address.
REQ-009 The block SHALL have port wptr, output, ADDR_SIZE+1 bits: registered Gray write pointer, for the read-domain synchroniser.
REQ-010 The block SHALL have port wen, output, 1 bit: RAM write enable, combinational winc & ~wfull.
REQ-011 The block SHALL have port wfull, output, 1 bit: registered full flag.
REQ-012 The block SHALL have port walmost_full, output, 1 bit: registered flag, level >= AFULL_TH.
REQ-013 The block SHALL have port wlevel, output, ADDR_SIZE+1 bits: registered fill level, 0..2**ADDR_SIZE.
REQ-014 The block SHALL have port wovf, output, 1 bit: sticky overflow flag.

Function
REQ-015 Binary write pointer wbin, ADDR_SIZE+1 bits: wbnext = wbin + wen, modulo 2**(ADDR_SIZE+1); wraps silently.
REQ-016 waddr SHALL equal wbin[ADDR_SIZE-1:0], i.e. the current register, not wbnext.
REQ-017 wgnext SHALL be (wbnext>>1)^wbnext; wptr SHALL register wgnext on each edge; exactly one wptr bit changes per accepted write.
REQ-018 Full decision: wfull SHALL be registered to (wgnext == {~r_sync[A:A-1], r_sync[A-2:0]}), A = ADDR_SIZE; the write that fills the FIFO asserts wfull on the same edge.
REQ-019 The block SHALL convert r_sync to binary rbin (XOR prefix from MSB), combinationally.
REQ-020 wlevel SHALL be registered to (wbnext - rbin) modulo 2**(ADDR_SIZE+1).
REQ-021 walmost_full SHALL be registered to (wbnext - rbin) >= AFULL_TH; with AFULL_TH = 2**ADDR_SIZE it equals wfull.
REQ-022 A write while full (winc=1, wfull=1) SHALL be dropped: wbin, wptr and waddr are unchanged and wen=0.
REQ-023 A write attempted while full SHALL set wovf on that edge.
REQ-024 wovf SHALL remain set until an edge with wovf_clr=1 and no new overflow; simultaneous overflow and clear SHALL leave wovf=1.
REQ-025 r_sync advancing while wfull=1 SHALL deassert wfull at the next edge; a write on that same edge is still dropped (decision uses the registered wfull).
REQ-026 Flags SHALL be pessimistic: stale r_sync may hold wfull or walmost_full high longer, never deassert them early.
REQ-027 Simultaneous winc and r_sync change SHALL both be reflected in the next wlevel.

Reset
REQ-028 When wrst=0, asynchronously: wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, wovf=0; waddr=0, wen=0 follow.
REQ-029 Reset asserted mid-operation SHALL abort any in-flight write; no write is accepted on the edge coinciding with reset release.

Structure
REQ-030 A shared package SHALL hold the default ADDR_SIZE and the bin2gray/gray2bin functions, used also by the read-side block.
REQ-031 Gray-to-binary conversion SHALL be one parametrised sub-module, gray2bin (width ADDR_SIZE+1), instanced once.

Verification
REQ-032 Reset, then 16 writes with r_sync=0 (ADDR_SIZE=4): wfull=1 after the 16th edge, wlevel=16, walmost_full=1 from the 14th edge.
REQ-033 When full, winc=1 for 1 cycle: waddr stays 0, wptr=5'b11000, wovf=1; wovf_clr pulse -> wovf=0; clear and overflow together -> wovf stays 1.
REQ-034 When full, r_sync steps to Gray 1: wfull=0 and wlevel=15 next edge; next write accepted at waddr=0.
REQ-035 Wrap: 40 writes with r_sync tracking wptr delayed 2 cycles: wptr changes by one bit per write, wbin wraps 31->0, wfull never set.
REQ-036 wrst pulsed low mid-burst, asynchronous to wclk: all outputs 0 immediately, first post-reset write goes to waddr=0.

Source files
------------

// File: rtl/wr_ptr_full_gen_pkg.sv
// Shared FIFO pointer definitions: default address width and Gray/binary helpers,
// used by both the write-side and read-side pointer blocks.
package wr_ptr_full_gen_pkg;

   localparam int DEFAULT_ADDR_SIZE = 4;
   localparam int MAX_PTR_W         = 17;

   typedef logic [MAX_PTR_W-1:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b = '0;
      for (int i = 0; i < MAX_PTR_W; i++) b[i] = ^(g >> i);
      return b;
   endfunction

endpackage

// File: rtl/wr_ptr_full_gen_if.sv
// Write-side pointer bus: write request/flag handshake plus the synchronised read pointer.
interface wr_ptr_full_gen_if
   import wr_ptr_full_gen_pkg::*;
#(
   parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
);
   logic                 winc;
   logic [ADDR_SIZE:0]   r_sync;
   logic                 wovf_clr;
   logic [ADDR_SIZE-1:0] waddr;
   logic [ADDR_SIZE:0]   wptr;
   logic                 wen;
   logic                 wfull;
   logic                 walmost_full;
   logic [ADDR_SIZE:0]   wlevel;
   logic                 wovf;

   modport master (
      output winc, r_sync, wovf_clr,
      input  waddr, wptr, wen, wfull, walmost_full, wlevel, wovf
   );

   modport slave (
      input  winc, r_sync, wovf_clr,
      output waddr, wptr, wen, wfull, walmost_full, wlevel, wovf
   );
endinterface

// File: rtl/wr_ptr_full_gen_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits from the MSB down to that position.
module gray2bin #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   always_comb begin
      // NOTE: every bit gets a default before the loop, so no partial assignment can infer a latch.
      bin = '0;
      for (int i = 0; i < WIDTH; i++) bin[i] = ^(gray >> i);
   end

endmodule

// File: rtl/wr_ptr_full_gen.sv
// Write-domain pointer and flag generator for an asynchronous FIFO: binary/Gray
// write pointer, registered full, almost-full, fill level and sticky overflow.
module wr_ptr_full_gen
   import wr_ptr_full_gen_pkg::*;
#(
   parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
   parameter int AFULL_TH  = 2**ADDR_SIZE - 2
) (
   input  logic             wclk,
   input  logic             wrst,
   wr_ptr_full_gen_if.slave bus
);

   localparam int PTR_W = ADDR_SIZE + 1;

   logic [PTR_W-1:0] wbin;
   logic [PTR_W-1:0] wbnext;
   logic [PTR_W-1:0] wgnext;
   logic [PTR_W-1:0] rbin;
   logic [PTR_W-1:0] full_ptr;
   logic [PTR_W-1:0] level_next;
   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] wlevel_q;
   logic             wfull_q;
   logic             walmost_full_q;
   logic             wovf_q;
   logic             wen;

   gray2bin #(.WIDTH(PTR_W)) u_gray2bin (
      .gray (bus.r_sync),
      .bin  (rbin)
   );

   // Gating with wrst keeps the RAM from being written while reset is held,
   // including on the edge that coincides with reset release.
   assign wen        = bus.winc & ~wfull_q & wrst;
   assign wbnext     = wbin + PTR_W'(wen);
   assign wgnext     = PTR_W'(bin2gray(ptr_t'(wbnext)));
   // Full when the write pointer is one lap ahead: top two Gray bits inverted.
   assign full_ptr   = {~bus.r_sync[ADDR_SIZE:ADDR_SIZE-1], bus.r_sync[ADDR_SIZE-2:0]};
   assign level_next = wbnext - rbin;

   always_ff @(posedge wclk or negedge wrst) begin
      if (!wrst) begin
         wbin           <= '0;
         wptr_q         <= '0;
         wfull_q        <= 1'b0;
         walmost_full_q <= 1'b0;
         wlevel_q       <= '0;
         wovf_q         <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         wbin           <= wbnext;
         wptr_q         <= wgnext;
         wfull_q        <= (wgnext == full_ptr);
         walmost_full_q <= (level_next >= PTR_W'(AFULL_TH));
         wlevel_q       <= level_next;
         wovf_q         <= (bus.winc & wfull_q) | (wovf_q & ~bus.wovf_clr);
      end
   end

   assign bus.waddr        = wbin[ADDR_SIZE-1:0];
   assign bus.wptr         = wptr_q;
   assign bus.wen          = wen;
   assign bus.wfull        = wfull_q;
   assign bus.walmost_full = walmost_full_q;
   assign bus.wlevel       = wlevel_q;
   assign bus.wovf         = wovf_q;

endmodule

// File: tb/tb_wr_ptr_full_gen.sv
// Self-checking bench for wr_ptr_full_gen (ADDR_SIZE=4): directed vector table,
// randomized traffic against a count-based FIFO model, wrap and async-reset sequences.
module tb_wr_ptr_full_gen;

   localparam int AS    = 4;
   localparam int DEPTH = 16;
   localparam int AFULL = DEPTH - 2;

   logic wclk;
   logic wrst;

   wr_ptr_full_gen_if #(.ADDR_SIZE(AS)) bus ();

   wr_ptr_full_gen #(.ADDR_SIZE(AS), .AFULL_TH(AFULL)) dut (
      .wclk (wclk),
      .wrst (wrst),
      .bus  (bus)
   );

   initial begin
      wclk = 1'b0;
      forever #5 wclk = ~wclk;
   end

   int checks = 0;
   int errors = 0;

   // Model: total accepted writes and total reads, as plain counts.
   int   m_wr;
   int   m_rd;
   logic m_full;
   logic m_ovf;

   typedef struct {
      logic       winc;
      logic       clr;
      int         rcnt;
      logic       exp_wen;
      logic       exp_full;
      logic       exp_afull;
      logic       exp_ovf;
      int         exp_level;
      int         exp_waddr;
      logic [4:0] exp_wptr;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [4:0] to_gray(input int n);
      logic [4:0] b;
      b = 5'(n % 32);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      int lvl;
      lvl = m_wr - m_rd;
      check({tag, " wfull"},        bus.wfull,        m_full);
      check({tag, " walmost_full"}, bus.walmost_full, lvl >= AFULL);
      check({tag, " wlevel"},       bus.wlevel,       lvl);
      check({tag, " wovf"},         bus.wovf,         m_ovf);
      check({tag, " waddr"},        bus.waddr,        m_wr % DEPTH);
      check({tag, " wptr"},         bus.wptr,         to_gray(m_wr));
   endtask

   // One write-clock cycle driven from posedge+1; checks wen before the edge and
   // all registered outputs after it against the model.
   task automatic cyc(input string tag, input logic wi, input int radv, input logic clr);
      logic exp_wen;
      bus.winc     = wi;
      m_rd         = m_rd + radv;
      bus.r_sync   = to_gray(m_rd);
      bus.wovf_clr = clr;
      #1;
      exp_wen = wi && !m_full;
      check({tag, " wen"}, bus.wen, exp_wen);
      @(posedge wclk);
      #1;
      m_ovf  = (wi && m_full) || (m_ovf && !clr);
      m_wr   = m_wr + int'(exp_wen);
      m_full = (m_wr - m_rd) == DEPTH;
      check_model(tag);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " wen"},          bus.wen,          0);
      check({tag, " waddr"},        bus.waddr,        0);
      check({tag, " wptr"},         bus.wptr,         0);
      check({tag, " wfull"},        bus.wfull,        0);
      check({tag, " walmost_full"}, bus.walmost_full, 0);
      check({tag, " wlevel"},       bus.wlevel,       0);
      check({tag, " wovf"},         bus.wovf,         0);
   endtask

   // Assert reset between edges with a write pending; release it mid-cycle.
   task automatic mid_reset(input string tag);
      bus.winc = 1'b1;
      #2 wrst = 1'b0;
      #1 check_all_zero({tag, " async"});
      @(posedge wclk);
      #1 check_all_zero({tag, " held"});
      #2 wrst = 1'b1;
      bus.winc     = 1'b0;
      bus.wovf_clr = 1'b0;
      bus.r_sync   = '0;
      m_wr = 0; m_rd = 0; m_full = 1'b0; m_ovf = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0] prev_wptr;
      int         hist1, hist2;

      for (int k = 1; k <= DEPTH; k++)
         vecs.push_back('{1'b1, 1'b0, 0, 1'b1, k == DEPTH, k >= AFULL, 1'b0, k, k % DEPTH, to_gray(k)});
      vecs.push_back('{1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 16, 0, 5'b11000}); // overflow
      vecs.push_back('{1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 0, 5'b11000}); // clear
      vecs.push_back('{1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 16, 0, 5'b11000}); // overflow again
      vecs.push_back('{1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b1, 16, 0, 5'b11000}); // clear + overflow
      vecs.push_back('{1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 0, 5'b11000}); // clear
      vecs.push_back('{1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 15, 0, 5'b11000}); // read 1 -> not full
      vecs.push_back('{1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 16, 1, 5'b11001}); // write at addr 0
      vecs.push_back('{1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b1, 15, 1, 5'b11001}); // read+write while full
      vecs.push_back('{1'b1, 1'b1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 16, 2, 5'b11011}); // write + clear

      wrst         = 1'b0;
      bus.winc     = 1'b0;
      bus.wovf_clr = 1'b0;
      bus.r_sync   = '0;
      #1 check_all_zero("reset");
      #11 wrst = 1'b1;

      // Directed table
      for (int i = 0; i < vecs.size(); i++) begin
         string tag;
         tag          = $sformatf("vec%0d", i);
         bus.winc     = vecs[i].winc;
         bus.wovf_clr = vecs[i].clr;
         bus.r_sync   = to_gray(vecs[i].rcnt);
         #1 check({tag, " wen"}, bus.wen, vecs[i].exp_wen);
         @(posedge wclk);
         #1;
         check({tag, " wfull"},        bus.wfull,        vecs[i].exp_full);
         check({tag, " walmost_full"}, bus.walmost_full, vecs[i].exp_afull);
         check({tag, " wovf"},         bus.wovf,         vecs[i].exp_ovf);
         check({tag, " wlevel"},       bus.wlevel,       vecs[i].exp_level);
         check({tag, " waddr"},        bus.waddr,        vecs[i].exp_waddr);
         check({tag, " wptr"},         bus.wptr,         vecs[i].exp_wptr);
      end

      // Randomized traffic against the count model
      mid_reset("rst_rand");
      for (int i = 0; i < 400; i++) begin
         logic wi, clr;
         int   radv, room;
         wi   = ($urandom_range(0, 3) != 0);
         clr  = ($urandom_range(0, 7) == 0);
         room = m_wr - m_rd;
         radv = (room > 0) ? $urandom_range(0, (room > 2) ? 2 : room) : 0;
         cyc("rand", wi, radv, clr);
      end

      // Wrap: reader follows the write count two cycles late
      mid_reset("rst_wrap");
      hist1 = 0; hist2 = 0;
      prev_wptr = bus.wptr;
      for (int k = 0; k < 40; k++) begin
         cyc("wrap", 1'b1, hist2 - m_rd, 1'b0);
         check("wrap one_bit_step", $countones(prev_wptr ^ bus.wptr), 1);
         check("wrap no_full", bus.wfull, 0);
         prev_wptr = bus.wptr;
         hist2 = hist1;
         hist1 = m_wr;
      end
      check("wrap final wptr", bus.wptr, 5'b01100);

      // Async reset mid-burst, then first write must land at address 0
      for (int k = 0; k < 5; k++) cyc("burst", 1'b1, 0, 1'b0);
      mid_reset("rst_burst");
      cyc("post_reset", 1'b1, 0, 1'b0);
      check("post_reset first waddr", bus.waddr, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
